riscv_decode_issue_buffer: RTL and testbench
============================================

// Module: riscv_decode_issue_buffer
// PURPOSE
// - Consumer side of the decode-stage register bank: captures decoded operand/control fields and issues them to execute.
// - Two-entry skid FIFO with valid/ready handshakes on both sides.
// - Decouples execute back-pressure from decode, so decode's ready never depends combinationally on execute's ready.
// - Supports a synchronous flush for branch redirect and trap.
// PARAMETERS
// - XLEN    `XLEN (32)  width of pc, rs1, rs2 and imm fields
// - CTRL_W  16          width of the opaque control-bundle field
// PORTS
// - i_clk        in   1       clock; all state changes on rising edge
// - i_rst        in   1       synchronous reset, active-high
// - i_clr        in   1       synchronous flush (pipeline kill)
// - i_valid      in   1       decode presents a valid bundle
// - o_ready      out  1       buffer can accept; high iff occupancy < 2
// - i_pc         in   XLEN    instruction pc
// - i_rs1        in   XLEN    rs1 operand value
// - i_rs2        in   XLEN    rs2 operand value
// - i_imm        in   XLEN    decoded immediate
// - i_rd         in   5       destination register index
// - i_ctrl       in   CTRL_W  control bundle, passed through unmodified
// - o_valid      out  1       head entry valid toward execute
// - i_ready      in   1       execute accepts head entry
// - o_pc/o_rs1/o_rs2/o_imm  out  XLEN  head entry fields
// - o_rd         out  5       head entry rd
// - o_ctrl       out  CTRL_W  head entry control
// - o_count      out  2       occupancy, 0..2
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-high on i_rst.
// - Reset values: o_count=0, o_valid=0, o_ready=1. Entry storage and data outputs are zeroed.
// - Push = i_valid & o_ready. Pop = o_valid & i_ready. Both take effect at the clock edge.
// - o_ready = (count != 2). It is a function of registered state only; there is no i_ready -> o_ready path.
// - FIFO order is strict: head = oldest entry. Read/write pointers are 1 bit and wrap 1 -> 0.
// - Without a bypass, an accepted bundle appears on o_valid/o_* in the next cycle (1-cycle latency).
// - Simultaneous events:
//   - Push and pop at count 1: count stays 1, and the new entry becomes head next cycle.
//   - At count 0, pop is impossible (o_valid=0).
//   - At count 2, push is impossible (o_ready=0). A pop at count 2 gives count 1, and o_ready=1 the next cycle.
// - o_* data holds stable while o_valid=1 and i_ready=0.
// - Flush (i_clr=1): count, pointers and o_valid clear next cycle. A push or pop in the same cycle is discarded.
//   o_ready=1 the next cycle. i_rst has priority over i_clr.
// - o_count always equals pushes minus pops since the last reset or flush. It never exceeds 2 and never underflows.
// CONFIGURATION
// - RISCV_ISSUE_BYPASS_EN defined:
//   - When count==0, i_valid=1 and i_clr=0, o_valid and o_* are driven combinationally from i_* (zero latency).
//   - If i_ready=1, the bundle is consumed that cycle and not stored.
//   - If i_ready=0, it is stored as head with count 1.
//   - o_ready is unaffected (still registered).
// - RISCV_ISSUE_BYPASS_EN undefined: no combinational input->output path; latency is always 1 cycle.
// TESTING
// - Reset: hold i_rst 2 cycles with i_valid=1 -> o_valid=0, o_count=0, o_ready=1, o_pc=0.
// - Back-pressure: push pc=0x100 then 0x104 with i_ready=0 -> o_count=2, o_ready=0, o_pc=0x100 held.
//   Raise i_ready -> 0x100 then 0x104 issued in order, o_ready=1 one cycle after the first pop.
// - Streaming: i_valid=1 and i_ready=1 for 8 cycles, pc 0x0..0x1C step 4 -> every pc issued once, in order.
//   o_count stays <=1 and o_ready=1 throughout.
// - Flush: count=2, then assert i_clr with i_valid=1 (pc=0x200) and i_ready=1 -> next cycle o_valid=0, o_count=0.
//   0x200 never appears on the output.
// - Simultaneous push/pop at count 1 (head 0x10, push 0x14) -> o_count=1, o_pc=0x14 next cycle.
// - Bypass: with RISCV_ISSUE_BYPASS_EN, count=0, push pc=0x40 with i_ready=1 -> o_valid=1 and o_pc=0x40 in the same cycle.
//   Without the macro, they appear the following cycle.

Source files
------------

// File: rtl/riscv_decode_issue_buffer_if.sv
// Issue bundle handshake: valid/ready plus the decoded operand and control fields.
// Master drives the bundle and valid; slave returns ready.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_decode_issue_buffer_if #(
  parameter int XLEN   = `XLEN,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [XLEN-1:0]   imm;
  logic [4:0]        rd;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, pc, rs1, rs2, imm, rd, ctrl, input ready);
  modport slave  (input valid, pc, rs1, rs2, imm, rd, ctrl, output ready);
endinterface

// File: rtl/riscv_decode_issue_buffer.sv
// Two-entry skid FIFO between decode and execute; upstream ready depends on registered occupancy only.
// Optional zero-latency path through an empty buffer: define RISCV_ISSUE_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_decode_issue_buffer #(
  parameter int XLEN   = `XLEN,
  parameter int CTRL_W = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_clr,
  riscv_decode_issue_buffer_if.slave        i_dec,
  riscv_decode_issue_buffer_if.master       o_exe,
  output logic [1:0]                        o_count
);
  localparam int ENT_W = 4*XLEN + 5 + CTRL_W;

  logic [ENT_W-1:0] r_mem [2];
  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;

  logic [ENT_W-1:0] w_in;
  logic [ENT_W-1:0] w_head;
  logic [ENT_W-1:0] w_out;
  logic             w_out_valid;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;

  assign w_in   = {i_dec.pc, i_dec.rs1, i_dec.rs2, i_dec.imm, i_dec.rd, i_dec.ctrl};
  assign w_head = r_mem[r_rd_ptr];

  assign w_ready     = (r_count != 2'd2);
  assign i_dec.ready = w_ready;

`ifdef RISCV_ISSUE_BYPASS_EN
  // An empty buffer forwards the incoming bundle; if execute stalls it is captured as head.
  logic w_byp;
  assign w_byp       = (r_count == 2'd0) && i_dec.valid && !i_clr && !i_rst;
  assign w_out_valid = (r_count != 2'd0) || w_byp;
  assign w_out       = w_byp ? w_in : w_head;
`else
  assign w_out_valid = (r_count != 2'd0);
  assign w_out       = w_head;
`endif

  assign o_exe.valid = w_out_valid;
  assign {o_exe.pc, o_exe.rs1, o_exe.rs2, o_exe.imm, o_exe.rd, o_exe.ctrl} = w_out;
  assign o_count     = r_count;

  assign w_push = i_dec.valid && w_ready;
  assign w_pop  = w_out_valid && o_exe.ready;

  // A bypassed push+pop advances both pointers together, so the slot is written but never seen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_clr) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_riscv_decode_issue_buffer.sv
// Directed bench for riscv_decode_issue_buffer; honours RISCV_ISSUE_BYPASS_EN for latency expectations.
`timescale 1ns/1ps

module tb_riscv_decode_issue_buffer;
  logic       clk;
  logic       rst;
  logic       clr;
  logic [1:0] count;
  int         n_checks;
  int         n_err;
  logic [31:0] next_exp;

  riscv_decode_issue_buffer_if #(.XLEN(32), .CTRL_W(16)) dec_if ();
  riscv_decode_issue_buffer_if #(.XLEN(32), .CTRL_W(16)) exe_if ();

  riscv_decode_issue_buffer #(.XLEN(32), .CTRL_W(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (clr),
    .i_dec   (dec_if),
    .o_exe   (exe_if),
    .o_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_rs1(logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
  function automatic logic [31:0] f_rs2(logic [31:0] pc); return pc + 32'h0000_1000; endfunction
  function automatic logic [31:0] f_imm(logic [31:0] pc); return ~pc; endfunction
  function automatic logic [4:0]  f_rd(logic [31:0] pc);  return pc[6:2] ^ 5'h1F; endfunction
  function automatic logic [15:0] f_ctrl(logic [31:0] pc); return pc[15:0] ^ 16'hC3C3; endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    dec_if.valid = v;
    dec_if.pc    = pc;
    dec_if.rs1   = f_rs1(pc);
    dec_if.rs2   = f_rs2(pc);
    dec_if.imm   = f_imm(pc);
    dec_if.rd    = f_rd(pc);
    dec_if.ctrl  = f_ctrl(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-24s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    clr = 1'b0;
    exe_if.ready = 1'b0;
    drive(1'b1, 32'h999);

    // reset held two cycles with valid asserted
    tick();
    tick();
    check("rst_valid", exe_if.valid, 0);
    check("rst_count", count, 0);
    check("rst_ready", dec_if.ready, 1);
    check("rst_pc", exe_if.pc, 0);

    // back-pressure: two pushes with execute stalled
    rst = 1'b0;
    drive(1'b1, 32'h100);
    #1;
`ifdef RISCV_ISSUE_BYPASS_EN
    check("bp_byp_valid", exe_if.valid, 1);
    check("bp_byp_pc", exe_if.pc, 32'h100);
`else
    check("bp_nobyp_valid", exe_if.valid, 0);
`endif
    tick();
    check("bp_count1", count, 1);
    drive(1'b1, 32'h104);
    tick();
    drive(1'b0, 32'h0);
    #1;
    check("bp_count2", count, 2);
    check("bp_ready0", dec_if.ready, 0);
    check("bp_head_pc", exe_if.pc, 32'h100);
    check("bp_head_rs1", exe_if.rs1, f_rs1(32'h100));
    check("bp_head_rs2", exe_if.rs2, f_rs2(32'h100));
    check("bp_head_imm", exe_if.imm, f_imm(32'h100));
    check("bp_head_rd", exe_if.rd, f_rd(32'h100));
    check("bp_head_ctrl", exe_if.ctrl, f_ctrl(32'h100));
    tick();
    check("bp_hold_pc", exe_if.pc, 32'h100);
    check("bp_hold_valid", exe_if.valid, 1);
    exe_if.ready = 1'b1;
    #1;
    check("bp_pop0_pc", exe_if.pc, 32'h100);
    tick();
    check("bp_pop1_pc", exe_if.pc, 32'h104);
    check("bp_pop1_count", count, 1);
    check("bp_pop1_ready", dec_if.ready, 1);
    tick();
    check("bp_empty_valid", exe_if.valid, 0);
    check("bp_empty_count", count, 0);

    // streaming eight bundles with execute always ready
    next_exp = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 32'(i * 4));
      else       drive(1'b0, 32'h0);
      #1;
      check("st_ready", dec_if.ready, 1);
      check("st_count_le1", (count <= 2'd1), 1);
      if (exe_if.valid) begin
        check("st_order_pc", exe_if.pc, next_exp);
        next_exp = next_exp + 32'd4;
      end
      tick();
    end
    check("st_all_issued", next_exp, 32'h20);
    check("st_drained", count, 0);

    // flush with a full buffer and a concurrent push/pop
    exe_if.ready = 1'b0;
    drive(1'b1, 32'h300);
    tick();
    drive(1'b1, 32'h304);
    tick();
    check("fl_count2", count, 2);
    clr = 1'b1;
    exe_if.ready = 1'b1;
    drive(1'b1, 32'h200);
    tick();
    clr = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    check("fl_valid", exe_if.valid, 0);
    check("fl_count", count, 0);
    check("fl_ready", dec_if.ready, 1);
    tick();
    check("fl_valid_after", exe_if.valid, 0);
    check("fl_count_after", count, 0);

    // simultaneous push and pop at occupancy one
    exe_if.ready = 1'b0;
    drive(1'b1, 32'h10);
    tick();
    drive(1'b1, 32'h14);
    exe_if.ready = 1'b1;
    #1;
    check("pp_count_before", count, 1);
    check("pp_head_before", exe_if.pc, 32'h10);
    tick();
    drive(1'b0, 32'h0);
    exe_if.ready = 1'b0;
    #1;
    check("pp_count_after", count, 1);
    check("pp_head_after", exe_if.pc, 32'h14);
    exe_if.ready = 1'b1;
    tick();
    check("pp_drained", count, 0);

    // zero-latency bypass versus one-cycle latency
    drive(1'b1, 32'h40);
    exe_if.ready = 1'b1;
    #1;
`ifdef RISCV_ISSUE_BYPASS_EN
    check("by_same_valid", exe_if.valid, 1);
    check("by_same_pc", exe_if.pc, 32'h40);
    tick();
    drive(1'b0, 32'h0);
    #1;
    check("by_next_valid", exe_if.valid, 0);
    check("by_next_count", count, 0);
`else
    check("by_same_valid", exe_if.valid, 0);
    tick();
    drive(1'b0, 32'h0);
    #1;
    check("by_next_valid", exe_if.valid, 1);
    check("by_next_pc", exe_if.pc, 32'h40);
    check("by_next_count", count, 1);
    tick();
    check("by_drained", count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
